reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, register and operand width; NREGS, default 16, register count; ADDR_W, default 4, register address width.
REQ-002 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, synchronous active-low reset.
REQ-004 Port ra_addr, input, ADDR_W, read port A address, which feeds ALU operand a.
REQ-005 Port rb_addr, input, ADDR_W, read port B address, which feeds ALU operand b.
REQ-006 Port rd_en, input, 1, general write enable (ALU result r).
REQ-007 Port rd_addr, input, ADDR_W, general write address.
REQ-008 Port rd_data, input, DATA_W, general write data.
REQ-009 Port r15_en, input, 1, dedicated R15 write enable for ALU R15 output (multiply high half / remainder).
REQ-010 Port r15_data, input, DATA_W, dedicated R15 write data.
REQ-011 Port ovf_in, input, 1, ALU overflow, sampled only when rd_en=1.
REQ-012 Port ovf_clr, input, 1, clears the sticky overflow flag.
REQ-013 Port a_out, output, DATA_W, registered operand A.
REQ-014 Port b_out, output, DATA_W, registered operand B.
REQ-015 Port ovf_flag, output, 1, sticky overflow status.
REQ-016 Port wr_conflict, output, 1, one-cycle pulse flagging a collision on R15.

Function
REQ-017 Reads SHALL be registered: a_out/b_out SHALL reflect the addressed register one cycle after the address is presented (latency 1).
REQ-018 Writes SHALL commit on the rising edge when enabled; rd_en writes rd_data to regs[rd_addr]; r15_en writes r15_data to regs[15].
REQ-019 Bypass: if a read address equals a register being written in the same cycle, the output SHALL capture the new write data, not the stale value.
REQ-020 If rd_en=1, rd_addr=15 and r15_en=1 in the same cycle, r15_data SHALL win, and the bypass SHALL return r15_data.
REQ-021 In the REQ-020 case, wr_conflict SHALL be 1 for exactly the following cycle; otherwise it is 0.
REQ-022 ovf_flag SHALL set when rd_en=1 and ovf_in=1, remain set until cleared, and clear when ovf_clr=1.
REQ-023 If ovf_clr and a setting event occur in the same cycle, the set SHALL take priority, so ovf_flag=1.
REQ-024 Every register, including R0, SHALL be general purpose and writable; there is no hardwired zero.
REQ-025 Addresses SHALL be full-range with no out-of-bounds case; with NREGS=16, all 4-bit addresses are valid.
REQ-026 Inputs SHALL be ignored while rst_n=0; no write or flag update occurs in a reset cycle.

Reset
REQ-027 On a clock edge with rst_n=0, all registers SHALL become 0.
REQ-028 On a clock edge with rst_n=0, a_out, b_out, ovf_flag and wr_conflict SHALL become 0.
REQ-029 A reset asserted mid-sequence SHALL discard the in-flight write in that cycle.
REQ-030 The first valid read SHALL follow the first edge with rst_n=1.

Structure
REQ-031 A shared package SHALL hold DATA_W, ADDR_W, NREGS and the constant R15_IDX=15; the ALU and the register file SHALL use it.
REQ-032 The register array, bypass mux, conflict detection and status flag SHALL be implemented in this module with no sub-module.
REQ-033 The read/bypass mux MAY be factored into one sub-module named rf_read_port, instantiated twice.

Verification
REQ-034 Reset then read all 16 addresses -> a_out=b_out=0000 and ovf_flag=0 for every address.
REQ-035 Write regs[3]=CCCC, then set ra=3 and rb=3 -> one cycle later a_out=b_out=CCCC.
REQ-036 Same-cycle rd_en to addr 5 with 1234 while ra=5 -> a_out=1234 next cycle (bypass).
REQ-037 rd_en to addr 15 with AAAA and r15_en with 5555 in the same cycle -> regs[15]=5555 and wr_conflict=1 for one cycle.
REQ-038 rd_en with ovf_in=1 -> ovf_flag=1 and held; ovf_clr with a simultaneous set -> still 1; ovf_clr alone -> 0.
REQ-039 Load regs[7]=FFFF, then drive rst_n=0 for one edge alongside a write of 0001 to addr 7 -> regs[7]=0000 and a_out=0000.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared sizing constants for the register file and the ALU that drives it,
// plus the bypass source encoding used by the read ports.
package reg_file_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int NREGS   = 16;
  localparam int R15_IDX = 15;

  typedef enum logic [1:0] {
    SRC_REG,
    SRC_RD,
    SRC_R15
  } byp_src_t;
endpackage

// File: rtl/rf_read_port.sv
// Combinational read mux for one port: selects the stored register value or
// same-cycle write data, so a read never returns a value that is being overwritten.
module rf_read_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              r15_en,
  input  logic [DATA_W-1:0] r15_data,
  output logic [DATA_W-1:0] data
);
  import reg_file_pkg::*;

  localparam logic [ADDR_W-1:0] R15_ADDR = ADDR_W'(R15_IDX);

  byp_src_t src;

  // R15 data is checked first so it wins over a general write to R15.
  always_comb begin
    src = SRC_REG;
    if (r15_en && addr == R15_ADDR)
      src = SRC_R15;
    else if (rd_en && addr == rd_addr)
      src = SRC_RD;
  end

  always_comb begin
    data = stored;
    case (src)
      SRC_R15: data = r15_data;
      SRC_RD:  data = rd_data;
      default: data = stored;
    endcase
  end
endmodule

// File: rtl/reg_file.sv
// General-purpose register file with two registered, write-bypassed read ports,
// a dedicated R15 write port, R15 collision detection and a sticky overflow flag.
module reg_file #(
  parameter int          DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned NREGS  = reg_file_pkg::NREGS,
  parameter int          ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              r15_en,
  input  logic [DATA_W-1:0] r15_data,
  input  logic              ovf_in,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              ovf_flag,
  output logic              wr_conflict
);
  import reg_file_pkg::*;

  localparam logic [ADDR_W-1:0] R15_ADDR = ADDR_W'(R15_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_stored, b_stored;
  logic [DATA_W-1:0] a_next, b_next;
  logic              conflict;

  assign a_stored = regs[ra_addr];
  assign b_stored = regs[rb_addr];
  assign conflict = rd_en && r15_en && (rd_addr == R15_ADDR);

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .addr     (ra_addr),
    .stored   (a_stored),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .r15_en   (r15_en),
    .r15_data (r15_data),
    .data     (a_next)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .addr     (rb_addr),
    .stored   (b_stored),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .r15_en   (r15_en),
    .r15_data (r15_data),
    .data     (b_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
      a_out       <= '0;
      b_out       <= '0;
      ovf_flag    <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      if (rd_en)
        regs[rd_addr] <= rd_data;
      // Later assignment overrides the general write when both target R15.
      if (r15_en)
        regs[R15_ADDR] <= r15_data;
      a_out       <= a_next;
      b_out       <= b_next;
      wr_conflict <= conflict;
      if (rd_en && ovf_in)
        ovf_flag <= 1'b1;
      else if (ovf_clr)
        ovf_flag <= 1'b0;
    end
  end
endmodule
